ts_stamp_grp: RTL

Parametrised multi-port timestamp capture block: the next generation of the single free-running 64-bit stamp counter that the MAC group shares between its rx and tx queues. It holds one programmable-increment time base and NUM_PORTS event inputs (for example per-MAC rx/tx start-of-frame strobes). Each event is stamped into a per-port FIFO, and software or a downstream RTT engine drains the FIFOs through one shared read port. It sits beside the MAC group in the core clock domain; overflow is counted per port.

---
 rtl/ts_stamp_grp.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ts_stamp_grp.sv
// ts_stamp_grp: shared time base with per-port event stamp FIFOs,
// one shared pop port and saturating per-port drop counters.
//
// Ports:
//   clk, reset        core clock, async active-low reset
//   ts_en, ts_incr    time base advance enable and step
//   ts_load(_val)     time base load, wins over advance
//   ts_now            current time base
//   ev_stamp          per-port event strobes
//   rd_req, rd_port   pop request and port select
//   rd_data, rd_valid popped stamp, valid one cycle after pop
//   fifo_empty/full   per-port FIFO flags
//   drop_clr          per-port drop counter clear
//   drop_cnt          packed per-port drop counters
module ts_stamp_grp #(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_SEL_W      = 2,
  parameter int TS_WIDTH        = 64,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ts_en,
  input  logic [7:0]             ts_incr,
  input  logic                   ts_load,
  input  logic [TS_WIDTH-1:0]    ts_load_val,
  output logic [TS_WIDTH-1:0]    ts_now,
  input  logic [NUM_PORTS-1:0]   ev_stamp,
  input  logic                   rd_req,
  input  logic [PORT_SEL_W-1:0]  rd_port,
  output logic [TS_WIDTH-1:0]    rd_data,
  output logic                   rd_valid,
  output logic [NUM_PORTS-1:0]   fifo_empty,
  output logic [NUM_PORTS-1:0]   fifo_full,
  input  logic [NUM_PORTS-1:0]   drop_clr,
  output logic [NUM_PORTS*DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int AW    = FIFO_DEPTH_BITS;
  localparam int PW    = FIFO_DEPTH_BITS + 1;

  typedef logic [PW-1:0]             ptr_t;
  typedef logic [TS_WIDTH-1:0]       ts_t;
  typedef logic [DROP_CNT_WIDTH-1:0] cnt_t;

  ts_t  mem [NUM_PORTS][DEPTH];
  ptr_t wp  [NUM_PORTS];
  ptr_t rp  [NUM_PORTS];
  cnt_t cnt [NUM_PORTS];

  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] wr;
  logic [NUM_PORTS-1:0] drop;
  ts_t                  pop_data;

  // A full FIFO still accepts an event when the same
  // cycle pops it; an empty FIFO never bypasses.
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    pop        = '0;
    wr         = '0;
    drop       = '0;
    pop_data   = '0;
    drop_cnt   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      fifo_empty[p] = (wp[p] == rp[p]);
      fifo_full[p]  = (wp[p][AW] != rp[p][AW]) &&
                      (wp[p][AW-1:0] == rp[p][AW-1:0]);
      pop[p]  = rd_req &&
                (rd_port == PORT_SEL_W'(p)) &&
                !fifo_empty[p];
      wr[p]   = ev_stamp[p] &&
                (!fifo_full[p] || pop[p]);
      drop[p] = ev_stamp[p] && !wr[p];
      if (pop[p])
        pop_data = mem[p][rp[p][AW-1:0]];
      drop_cnt[p*DROP_CNT_WIDTH +: DROP_CNT_WIDTH]
        = cnt[p];
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr[p])
        mem[p][wp[p][AW-1:0]] <= ts_now;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_now   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        wp[p]  <= '0;
        rp[p]  <= '0;
        cnt[p] <= '0;
      end
    end else begin
      if (ts_load)
        ts_now <= ts_load_val;
      else if (ts_en)
        ts_now <= ts_now + TS_WIDTH'(ts_incr);
      rd_valid <= |pop;
      if (|pop)
        rd_data <= pop_data;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wr[p])
          wp[p] <= wp[p] + 1'b1;
        if (pop[p])
          rp[p] <= rp[p] + 1'b1;
        if (drop_clr[p])
          cnt[p] <= '0;
        else if (drop[p] && cnt[p] != '1)
          cnt[p] <= cnt[p] + 1'b1;
      end
    end
  end

endmodule
